gmii_frame_gen: RTL and testbench
=================================

GMII_FRAME_GEN -- requirements
Module: gmii_frame_gen

Interface
REQ-001 Parameter MAX_LEN, 64, maximum payload octets per frame (>= 2).
REQ-002 Parameter LEN_W, 7, width of length/index fields; 2^LEN_W > MAX_LEN.
REQ-003 Parameter IFG, 7, idle cycles between frames of one burst (>= 1).
REQ-004 Parameter NFR_W, 4, width of frame-count fields.
REQ-005 GTX_CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 RESET  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; launches a burst when idle.
REQ-008 num_frames  in  NFR_W  frames per burst; 0 treated as 1.
REQ-009 pay_len  in  LEN_W  payload octets per frame; clamped to the range 1..MAX_LEN.
REQ-010 mode  in  1  payload source: 0 = incrementing, 1 = LFSR.
REQ-011 seed  in  8  first payload octet (mode 0) or LFSR seed (mode 1; 0 replaced by 8'h01).
REQ-012 err_en  in  2  bit k enables error injection at index err_idxk.
REQ-013 err_idx0, err_idx1  in  LEN_W each  payload indices (0-based) replaced by 8'hFF.
REQ-014 TX_EN  out  1  high during the start octet and payload.
REQ-015 tx_octet  out  8  transmitted octet.
REQ-016 busy  out  1  high from the cycle after start is accepted until the burst ends.
REQ-017 done  out  1  one-cycle pulse when the burst completes.
REQ-018 frames_sent  out  NFR_W  frames completed in the current or last burst.

Function
REQ-019 FSM states: IDLE, SOP, DATA, EOP, EXT, GAP; one octet per cycle.
REQ-020 IDLE: TX_EN=0, tx_octet=8'h00; start=1 -> SOP next cycle.
REQ-021 All inputs latched at start acceptance; later changes affect nothing until the next burst.
REQ-022 SOP: TX_EN=1, tx_octet=8'hFB; -> DATA.
REQ-023 DATA: TX_EN=1; emits payload indices 0..L-1 (L = clamped pay_len); -> EOP after index L-1.
REQ-024 Mode 0: octet i = seed + i mod 256; the sequence restarts from seed for each frame.
REQ-025 Mode 1: Fibonacci LFSR x^8+x^6+x^5+x^4+1; index 0 = seed, the register advances once per payload octet, and it continues across frames.
REQ-026 Error injection: if err_en[k]=1 and index == err_idxk, the octet is 8'hFF and the LFSR or counter still advances; an index >= L never fires.
REQ-027 EOP: TX_EN=0, tx_octet=8'hFD; frames_sent increments; -> EXT.
REQ-028 EXT: TX_EN=0, tx_octet=8'hF7; if the last frame -> IDLE with done=1 in this cycle; otherwise -> GAP.
REQ-029 GAP: TX_EN=0, tx_octet=8'h00 for exactly IFG cycles; -> SOP.
REQ-030 Frame length on the wire = L+3 cycles; burst length = N*(L+3) + (N-1)*IFG cycles.
REQ-031 start while busy is ignored, including in the EXT cycle of the last frame.
REQ-032 start accepted in IDLE clears frames_sent to 0.
REQ-033 frames_sent saturates at 2^NFR_W-1 and is held after done until the next start.
REQ-034 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-035 RESET low forces asynchronously: IDLE, TX_EN=0, tx_octet=8'h00, busy=0, done=0, frames_sent=0, and the LFSR and counters cleared.
REQ-036 Reset asserted mid-frame aborts immediately with no FD/F7 emitted; after release the block waits in IDLE for a new start.

Verification
REQ-037 num_frames=1, pay_len=9, mode=0, seed=8'h05, err_en=0 -> FB, 05..0D with TX_EN=1; FD, F7 with TX_EN=0; done pulse in the F7 cycle; frames_sent=1.
REQ-038 The same burst with err_en=01, err_idx0=3 -> payload octet 3 = FF, other octets unchanged, length 12 cycles.
REQ-039 err_en=11, err_idx0=3, err_idx1=6, num_frames=3 -> two FF octets per frame, 7 idle cycles between each EXT and the next FB, frames_sent=3.
REQ-040 mode=1, seed=0 -> first payload octet 8'h01 and continuous LFSR sequence across frames; pay_len=0 gives 1 octet; pay_len=127 gives MAX_LEN octets.
REQ-041 RESET pulled low during DATA -> outputs 0 within the same cycle; start pulses during the burst and in the EXT cycle are ignored.

Source files
------------

// File: rtl/gmii_frame_gen.sv
// GMII test-frame burst generator: emits N frames of FB / payload / FD / F7,
// separated by IFG idle octets, with incrementing or LFSR payload and optional error octets.
module gmii_frame_gen #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7,
  parameter int IFG     = 7,
  parameter int NFR_W   = 4
) (
  input  logic             GTX_CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [NFR_W-1:0] num_frames,
  input  logic [LEN_W-1:0] pay_len,
  input  logic             mode,
  input  logic [7:0]       seed,
  input  logic [1:0]       err_en,
  input  logic [LEN_W-1:0] err_idx0,
  input  logic [LEN_W-1:0] err_idx1,
  output logic             TX_EN,
  output logic [7:0]       tx_octet,
  output logic             busy,
  output logic             done,
  output logic [NFR_W-1:0] frames_sent
);

  localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;

  typedef enum logic [2:0] {IDLE, SOP, DATA, EOP, EXT, GAP} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_l, idx, err_idx0_l, err_idx1_l;
  logic [NFR_W-1:0] nfr_l;
  logic             mode_l;
  logic [7:0]       seed_l, pat;
  logic [1:0]       err_en_l;
  logic [GAP_W-1:0] gap_cnt;

  logic [LEN_W-1:0] len_clamped;
  logic [7:0]       pat_next, pay_octet;
  logic             hit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    len_clamped = pay_len;
    if (pay_len == '0)
      len_clamped = LEN_W'(1);
    else if (pay_len > LEN_W'(MAX_LEN))
      len_clamped = LEN_W'(MAX_LEN);

    // Left-shifting Fibonacci LFSR, taps for x^8+x^6+x^5+x^4+1.
    pat_next = mode_l ? {pat[6:0], pat[7] ^ pat[5] ^ pat[4] ^ pat[3]} : pat + 8'd1;

    hit       = (err_en_l[0] && idx == err_idx0_l) || (err_en_l[1] && idx == err_idx1_l);
    pay_octet = hit ? 8'hFF : pat;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      TX_EN       <= 1'b0;
      tx_octet    <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
      len_l       <= '0;
      idx         <= '0;
      err_idx0_l  <= '0;
      err_idx1_l  <= '0;
      nfr_l       <= '0;
      mode_l      <= 1'b0;
      seed_l      <= 8'h00;
      pat         <= 8'h00;
      err_en_l    <= 2'b00;
      gap_cnt     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          TX_EN    <= 1'b0;
          tx_octet <= 8'h00;
          if (start) begin
            state       <= SOP;
            TX_EN       <= 1'b1;
            tx_octet    <= 8'hFB;
            busy        <= 1'b1;
            frames_sent <= '0;
            len_l       <= len_clamped;
            nfr_l       <= (num_frames == '0) ? NFR_W'(1) : num_frames;
            mode_l      <= mode;
            seed_l      <= seed;
            err_en_l    <= err_en;
            err_idx0_l  <= err_idx0;
            err_idx1_l  <= err_idx1;
            idx         <= '0;
            pat         <= (mode && seed == 8'h00) ? 8'h01 : seed;
          end
        end
        SOP, DATA: begin
          if (state == DATA && idx == len_l) begin
            state    <= EOP;
            TX_EN    <= 1'b0;
            tx_octet <= 8'hFD;
            if (frames_sent != '1) frames_sent <= frames_sent + NFR_W'(1);
          end else begin
            state    <= DATA;
            tx_octet <= pay_octet;
            pat      <= pat_next;
            idx      <= idx + LEN_W'(1);
          end
        end
        EOP: begin
          state    <= EXT;
          tx_octet <= 8'hF7;
          done     <= (frames_sent == nfr_l);
        end
        EXT: begin
          tx_octet <= 8'h00;
          idx      <= '0;
          // The incrementing pattern restarts per frame; the LFSR runs on across frames.
          if (!mode_l) pat <= seed_l;
          if (frames_sent == nfr_l) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= GAP;
            gap_cnt <= GAP_W'(IFG - 1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state    <= SOP;
            TX_EN    <= 1'b1;
            tx_octet <= 8'hFB;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Self-checking bench for gmii_frame_gen: directed and randomized bursts compared cycle by
// cycle against a frame-level reference model built from the octet-sequence rules.
module tb_gmii_frame_gen;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
  localparam int IFG     = 7;
  localparam int NFR_W   = 4;

  logic             GTX_CLK, RESET, start, mode;
  logic [NFR_W-1:0] num_frames;
  logic [LEN_W-1:0] pay_len, err_idx0, err_idx1;
  logic [7:0]       seed;
  logic [1:0]       err_en;
  logic             TX_EN, busy, done;
  logic [7:0]       tx_octet;
  logic [NFR_W-1:0] frames_sent;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       en;
    logic [7:0] oct;
    logic       dn;
    int         fs;
  } exp_t;

  gmii_frame_gen #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .IFG(IFG), .NFR_W(NFR_W)) dut (
    .GTX_CLK(GTX_CLK), .RESET(RESET), .start(start), .num_frames(num_frames),
    .pay_len(pay_len), .mode(mode), .seed(seed), .err_en(err_en),
    .err_idx0(err_idx0), .err_idx1(err_idx1), .TX_EN(TX_EN), .tx_octet(tx_octet),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  initial GTX_CLK = 1'b0;
  always #5 GTX_CLK = ~GTX_CLK;

  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
  endfunction

  task automatic randomize_inputs(input bit with_start);
    start      = with_start ? 1'($urandom_range(0, 1)) : 1'b0;
    num_frames = NFR_W'($urandom);
    pay_len    = LEN_W'($urandom);
    mode       = 1'($urandom);
    seed       = 8'($urandom);
    err_en     = 2'($urandom);
    err_idx0   = LEN_W'($urandom);
    err_idx1   = LEN_W'($urandom);
  endtask

  task automatic check_idle(input string tag, input int fs);
    n_checks++;
    if ({TX_EN, tx_octet, busy, done} !== {1'b0, 8'h00, 1'b0, 1'b0} || int'(frames_sent) != fs) begin
      n_fail++;
      $display("FAIL %s idle: got en=%b oct=%h busy=%b done=%b fs=%0d, want en=0 oct=00 busy=0 done=0 fs=%0d",
               tag, TX_EN, tx_octet, busy, done, frames_sent, fs);
    end
  endtask

  // Launches one burst and compares every cycle of it against the reference model.
  task automatic run_burst(input int nf, input int pl, input int md, input int sd, input int ee,
                           input int e0, input int e1, input bit noise, input string tag);
    exp_t q[$];
    exp_t e;
    int   len, n, pay_cnt;
    logic [7:0] lf;
    len = (pl == 0) ? 1 : ((pl > MAX_LEN) ? MAX_LEN : pl);
    n   = (nf == 0) ? 1 : nf;
    lf  = (sd == 0) ? 8'h01 : 8'(sd);
    pay_cnt = 0;
    for (int f = 0; f < n; f++) begin
      q.push_back('{1'b1, 8'hFB, 1'b0, f});
      for (int i = 0; i < len; i++) begin
        e = '{1'b1, (md != 0) ? lf : 8'(sd + i), 1'b0, f};
        if (md != 0) lf = lfsr_step(lf);
        if (((ee & 1) != 0 && i == e0) || ((ee & 2) != 0 && i == e1)) e.oct = 8'hFF;
        q.push_back(e);
      end
      q.push_back('{1'b0, 8'hFD, 1'b0, f + 1});
      q.push_back('{1'b0, 8'hF7, (f == n - 1), f + 1});
      if (f < n - 1)
        for (int g = 0; g < IFG; g++) q.push_back('{1'b0, 8'h00, 1'b0, f + 1});
    end

    start      = 1'b1;
    num_frames = NFR_W'(nf);
    pay_len    = LEN_W'(pl);
    mode       = 1'(md);
    seed       = 8'(sd);
    err_en     = 2'(ee);
    err_idx0   = LEN_W'(e0);
    err_idx1   = LEN_W'(e1);
    @(negedge GTX_CLK);
    start = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      n_checks++;
      if (TX_EN !== q[k].en || tx_octet !== q[k].oct || done !== q[k].dn ||
          busy !== 1'b1 || int'(frames_sent) != q[k].fs) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got en=%b oct=%h done=%b busy=%b fs=%0d, want en=%b oct=%h done=%b busy=1 fs=%0d",
                 tag, k, TX_EN, tx_octet, done, busy, frames_sent, q[k].en, q[k].oct, q[k].dn, q[k].fs);
      end
      if (q[k].oct == 8'hFF && q[k].en) pay_cnt++;
      // Scramble inputs (start pulses included, EXT cycle too) to show they have no effect.
      if (noise) randomize_inputs(1'b1);
      @(negedge GTX_CLK);
    end
    start = 1'b0;
    check_idle(tag, n);
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    randomize_inputs(1'b0);
    start = 1'b1;
    #12;
    check_idle("reset_hold", 0);
    start = 1'b0;
    @(negedge GTX_CLK);
    RESET = 1'b1;
    repeat (2) @(negedge GTX_CLK);
    check_idle("reset_release", 0);
  endtask

  task automatic test_directed;
    run_burst(1, 9, 0, 8'h05, 0, 0, 0, 1'b0, "basic_incr");
    run_burst(1, 9, 0, 8'h05, 1, 3, 0, 1'b0, "err_idx0");
    run_burst(3, 9, 0, 8'h05, 3, 3, 6, 1'b0, "err_both_3fr");
    run_burst(1, 4, 0, 8'h05, 3, 4, 100, 1'b0, "err_out_of_range");
    run_burst(2, 3, 0, 8'hFE, 0, 0, 0, 1'b0, "incr_wrap");
  endtask

  task automatic test_lfsr_and_clamp;
    run_burst(3, 5, 1, 8'h00, 0, 0, 0, 1'b0, "lfsr_seed0");
    run_burst(2, 7, 1, 8'hA5, 2, 0, 2, 1'b0, "lfsr_err");
    run_burst(2, 0, 0, 8'h10, 0, 0, 0, 1'b0, "len_zero");
    run_burst(1, 127, 1, 8'h3C, 0, 0, 0, 1'b0, "len_127");
    run_burst(0, 2, 0, 8'h20, 0, 0, 0, 1'b0, "nfr_zero");
  endtask

  task automatic test_back_to_back;
    run_burst(2, 6, 0, 8'h40, 0, 0, 0, 1'b1, "b2b_a");
    run_burst(1, 3, 1, 8'h81, 1, 1, 0, 1'b1, "b2b_b");
  endtask

  task automatic test_random;
    for (int t = 0; t < 25; t++)
      run_burst($urandom_range(0, 5), $urandom_range(0, 127), $urandom_range(0, 1),
                $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 70),
                $urandom_range(0, 70), 1'b1, $sformatf("rand%0d", t));
  endtask

  task automatic test_reset_mid;
    start = 1'b1; num_frames = 4'd2; pay_len = 7'd9; mode = 1'b0; seed = 8'h05;
    err_en = 2'b00; err_idx0 = '0; err_idx1 = '0;
    @(negedge GTX_CLK);
    start = 1'b0;
    repeat (4) @(negedge GTX_CLK);
    #2 RESET = 1'b0;
    #1 check_idle("reset_mid_async", 0);
    @(negedge GTX_CLK);
    RESET = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check_idle($sformatf("reset_mid_after%0d", c), 0);
      @(negedge GTX_CLK);
    end
    run_burst(1, 9, 0, 8'h05, 0, 0, 0, 1'b0, "after_reset");
  endtask

  initial begin
    start = 1'b0;
    test_reset;
    test_directed;
    test_lfsr_and_clamp;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
